// File: rtl/step_pkg.sv
// ============================================================================
// step_pkg : shared FSM state type and default widths for step_dispatch
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package step_pkg;

  localparam int STEP_DATA_W = 8;
  localparam int STEP_CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/step_watchdog.sv
// ============================================================================
// step_watchdog : saturating cycle counter with clear, enable and limit hit
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module step_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the LIMIT-th enabled cycle so the caller leaves on that edge.
  assign hit_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/step_dispatch.sv
// ============================================================================
// step_dispatch : iterates a job through a start/done step unit count times
// Optional      : STEP_TIMEOUT_EN adds a WAIT watchdog that aborts with res_err
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module step_dispatch
  import step_pkg::*;
#(
  parameter int DATA_W      = STEP_DATA_W,
  parameter int CNT_W       = STEP_CNT_W,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_data,
  input  logic [CNT_W-1:0]  job_count,
  output logic              step_start,
  output logic [DATA_W-1:0] step_in_data,
  input  logic [DATA_W-1:0] step_out_data,
  input  logic              step_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q;
  logic               job_ready_q;
  logic               step_start_q;
  logic               res_valid_q;
  logic               busy_q;
  logic [DATA_W-1:0]  acc_q;
  logic [CNT_W-1:0]   rem_q;

`ifdef STEP_TIMEOUT_EN
  logic res_err_q;
  logic wd_hit;

  step_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != S_WAIT),
    .en_i  ((state_q == S_WAIT) && !step_done),
    .hit_o (wd_hit)
  );

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      job_ready_q  <= 1'b1;
      step_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      acc_q        <= '0;
      rem_q        <= '0;
`ifdef STEP_TIMEOUT_EN
      res_err_q    <= 1'b0;
`endif
    end else begin
      step_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            acc_q       <= job_data;
            rem_q       <= job_count;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (job_count == '0) begin
              state_q     <= S_RESULT;
              res_valid_q <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              step_start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (step_done) begin
            acc_q <= step_out_data;
            rem_q <= rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
              state_q     <= S_RESULT;
              res_valid_q <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              step_start_q <= 1'b1;
            end
          end
`ifdef STEP_TIMEOUT_EN
          // acc keeps the last good value; remaining iterations are dropped.
          else if (wd_hit) begin
            state_q     <= S_RESULT;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
          end
`endif
        end
        S_RESULT: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef STEP_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // acc is only written in IDLE and WAIT, so it is stable through ISSUE and RESULT.
  assign job_ready    = job_ready_q;
  assign step_start   = step_start_q;
  assign step_in_data = acc_q;
  assign res_valid    = res_valid_q;
  assign res_data     = acc_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire
